// File: rtl/sup1_defs_pkg.sv
// Shared definitions for the SUP-1 control path.
// Holds the opcode encodings, the control-word bit layout and the fixed
// micro-step numbers used by the sequencer and its microcode ROM.
package sup1_defs;

    // Opcodes (IR[7:4]); 9..D are unused and behave as NOP.
    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    // Control-word bit indices (pc_up is not part of the word; it is constant).
    localparam int CW_WIDTH = 15;
    localparam int CW_CO  = 14;
    localparam int CW_CE  = 13;
    localparam int CW_JMP = 12;
    localparam int CW_MI  = 11;
    localparam int CW_RI  = 10;
    localparam int CW_RO  = 9;
    localparam int CW_II  = 8;
    localparam int CW_IO  = 7;
    localparam int CW_AI  = 6;
    localparam int CW_AO  = 5;
    localparam int CW_BI  = 4;
    localparam int CW_EO  = 3;
    localparam int CW_SU  = 2;
    localparam int CW_FI  = 1;
    localparam int CW_OI  = 0;

    // Micro-step numbers.
    localparam int T_FETCH0 = 0;
    localparam int T_FETCH1 = 1;
    localparam int T_EXEC0  = 2;
    localparam int T_EXEC1  = 3;
    localparam int T_EXEC2  = 4;

    typedef logic [CW_WIDTH-1:0] cw_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode for SUP-1: maps (step, opcode, flags) to the
// control word. No state; halt/reset masking is done by the sequencer.
// Ports:
//   step    in  SW        current micro-step
//   opcode  in  OPW       IR[7:4]
//   flag_c  in  1         ALU carry flag (only consulted in T2)
//   flag_z  in  1         ALU zero flag  (only consulted in T2)
//   cw      out CW_WIDTH  control word, bit layout from sup1_defs
module microcode_rom
    import sup1_defs::*;
#(
    parameter int OPW = 4,
    parameter int SW  = 3
) (
    input  logic [SW-1:0]  step,
    input  logic [OPW-1:0] opcode,
    input  logic           flag_c,
    input  logic           flag_z,
    output cw_t            cw
);

    always_comb begin
        cw = '0;
        if (step == SW'(T_FETCH0)) begin
            cw[CW_CO] = 1'b1;
            cw[CW_MI] = 1'b1;
        end else if (step == SW'(T_FETCH1)) begin
            cw[CW_RO] = 1'b1;
            cw[CW_II] = 1'b1;
            cw[CW_CE] = 1'b1;
        end else if (step == SW'(T_EXEC0)) begin
            case (int'(opcode))
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    cw[CW_IO] = 1'b1;
                    cw[CW_MI] = 1'b1;
                end
                OP_LDI: begin
                    cw[CW_IO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                end
                OP_JMP: begin
                    cw[CW_IO]  = 1'b1;
                    cw[CW_JMP] = 1'b1;
                end
                // Conditional jumps decide here only; later steps ignore flags.
                OP_JC: begin
                    cw[CW_IO]  = flag_c;
                    cw[CW_JMP] = flag_c;
                end
                OP_JZ: begin
                    cw[CW_IO]  = flag_z;
                    cw[CW_JMP] = flag_z;
                end
                OP_OUT: begin
                    cw[CW_AO] = 1'b1;
                    cw[CW_OI] = 1'b1;
                end
                default: ;
            endcase
        end else if (step == SW'(T_EXEC1)) begin
            case (int'(opcode))
                OP_LDA: begin
                    cw[CW_RO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw[CW_RO] = 1'b1;
                    cw[CW_BI] = 1'b1;
                end
                OP_STA: begin
                    cw[CW_AO] = 1'b1;
                    cw[CW_RI] = 1'b1;
                end
                default: ;
            endcase
        end else if (step == SW'(T_EXEC2)) begin
            if (int'(opcode) == OP_ADD || int'(opcode) == OP_SUB) begin
                cw[CW_EO] = 1'b1;
                cw[CW_AI] = 1'b1;
                cw[CW_FI] = 1'b1;
                cw[CW_SU] = (int'(opcode) == OP_SUB);
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SUP-1 control sequencer: steps the fetch/execute ring and drives all
// bus/register strobes from the microcode ROM. One instruction per STEPS clocks.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode            IR[7:4]
//   flag_c, flag_z    registered ALU flags
//   step              current micro-step (forced 0 while rst is high)
//   hlt               machine halted
//   co ce jmp pc_up   PC strobes (pc_up constant 1)
//   mi ri ro          MAR/RAM strobes
//   ii io             IR strobes
//   ai ao bi          A/B register strobes
//   eo su fi          ALU / flag strobes
//   oi                output register load
module control_sequencer
    import sup1_defs::*;
#(
    parameter int OPW   = 4,
    parameter int STEPS = 5,
    parameter int SW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           flag_c,
    input  logic           flag_z,
    output logic [SW-1:0]  step,
    output logic           hlt,
    output logic           co,
    output logic           ce,
    output logic           jmp,
    output logic           pc_up,
    output logic           mi,
    output logic           ri,
    output logic           ro,
    output logic           ii,
    output logic           io,
    output logic           ai,
    output logic           ao,
    output logic           bi,
    output logic           eo,
    output logic           su,
    output logic           fi,
    output logic           oi
);

    logic [SW-1:0] step_q;
    logic          halted;
    cw_t           rom_cw;
    cw_t           cw;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            // HLT latches at the end of T2; the step still advances to T3 and freezes there.
            if (step_q == SW'(T_EXEC0) && opcode == OPW'(OP_HLT))
                halted <= 1'b1;
            step_q <= (step_q == SW'(STEPS - 1)) ? '0 : step_q + 1'b1;
        end
    end

    microcode_rom #(.OPW(OPW), .SW(SW)) u_rom (
        .step   (step_q),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .cw     (rom_cw)
    );

    // Reset and halt both silence the whole word so no consumer sees a stray strobe.
    assign cw    = (rst || halted) ? '0 : rom_cw;
    assign step  = rst ? '0 : step_q;
    assign hlt   = halted & ~rst;
    assign pc_up = 1'b1;

    assign co  = cw[CW_CO];
    assign ce  = cw[CW_CE];
    assign jmp = cw[CW_JMP];
    assign mi  = cw[CW_MI];
    assign ri  = cw[CW_RI];
    assign ro  = cw[CW_RO];
    assign ii  = cw[CW_II];
    assign io  = cw[CW_IO];
    assign ai  = cw[CW_AI];
    assign ao  = cw[CW_AO];
    assign bi  = cw[CW_BI];
    assign eo  = cw[CW_EO];
    assign su  = cw[CW_SU];
    assign fi  = cw[CW_FI];
    assign oi  = cw[CW_OI];

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;
    logic [2:0] step;
    logic       hlt, co, ce, jmp, pc_up, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi;

    control_sequencer #(.OPW(4), .STEPS(5), .SW(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step(step), .hlt(hlt), .co(co), .ce(ce), .jmp(jmp), .pc_up(pc_up),
        .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io), .ai(ai), .ao(ao),
        .bi(bi), .eo(eo), .su(su), .fi(fi), .oi(oi)
    );

    always #5 clk = ~clk;

    // Bench-side packing of the strobes, independent of the RTL bit layout.
    localparam logic [14:0] K_CO = 15'h4000, K_CE = 15'h2000, K_JMP = 15'h1000,
                            K_MI = 15'h0800, K_RI = 15'h0400, K_RO  = 15'h0200,
                            K_II = 15'h0100, K_IO = 15'h0080, K_AI  = 15'h0040,
                            K_AO = 15'h0020, K_BI = 15'h0010, K_EO  = 15'h0008,
                            K_SU = 15'h0004, K_FI = 15'h0002, K_OI  = 15'h0001;
    localparam logic [14:0] K_NONE = 15'h0000;
    localparam logic [14:0] K_F0 = K_CO | K_MI;
    localparam logic [14:0] K_F1 = K_RO | K_II | K_CE;

    logic [14:0] dut_cw;
    assign dut_cw = {co, ce, jmp, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi};

    typedef struct {
        logic [2:0]  stp;
        logic        hl;
        logic [14:0] cw;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Issue one cycle of stimulus and queue what the DUT must show in that cycle.
    task automatic drive(input logic r, input logic [3:0] op, input logic fc, input logic fz,
                         input logic [2:0] es, input logic eh, input logic [14:0] ecw,
                         input string nm);
        exp_t e;
        rst = r; opcode = op; flag_c = fc; flag_z = fz;
        e.stp = es; e.hl = eh; e.cw = ecw; e.nm = nm;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Full 5-step instruction: fc2 is flag_c during T0..T2, fc34 during T3/T4.
    task automatic instr(input logic [3:0] op, input logic fc2, input logic fc34, input logic fz,
                         input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4,
                         input string nm);
        drive(1'b0, op, fc2,  fz, 3'd0, 1'b0, K_F0, {nm, "_T0"});
        drive(1'b0, op, fc2,  fz, 3'd1, 1'b0, K_F1, {nm, "_T1"});
        drive(1'b0, op, fc2,  fz, 3'd2, 1'b0, e2,   {nm, "_T2"});
        drive(1'b0, op, fc34, fz, 3'd3, 1'b0, e3,   {nm, "_T3"});
        drive(1'b0, op, fc34, fz, 3'd4, 1'b0, e4,   {nm, "_T4"});
    endtask

    // Monitor: compares queued expectations and checks bus invariants every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (step !== e.stp || hlt !== e.hl || dut_cw !== e.cw || pc_up !== 1'b1) begin
                fails++;
                $display("FAIL %s: got step=%0d hlt=%b cw=%h pc_up=%b, want step=%0d hlt=%b cw=%h pc_up=1",
                         e.nm, step, hlt, dut_cw, pc_up, e.stp, e.hl, e.cw);
            end
        end
        if ($time > 0) begin
            tests++;
            if ($countones({co, ro, io, ao, eo}) > 1 || (jmp && ce) || (ri && ro)) begin
                fails++;
                $display("FAIL invariant: got co=%b ro=%b io=%b ao=%b eo=%b jmp=%b ce=%b ri=%b, want one bus driver, no jmp&ce, no ri&ro",
                         co, ro, io, ao, eo, jmp, ce, ri);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "reset0");
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "reset1");

        instr(4'h2, 1'b0, 1'b0, 1'b0, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI, "ADD");

        // ADD again, reset held for three cycles starting in T3
        drive(1'b0, 4'h2, 1'b0, 1'b0, 3'd0, 1'b0, K_F0, "ADDr_T0");
        drive(1'b0, 4'h2, 1'b0, 1'b0, 3'd1, 1'b0, K_F1, "ADDr_T1");
        drive(1'b0, 4'h2, 1'b0, 1'b0, 3'd2, 1'b0, K_IO | K_MI, "ADDr_T2");
        drive(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "rst_midT3_a");
        drive(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "rst_midT3_b");
        drive(1'b1, 4'h2, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "rst_midT3_c");

        instr(4'h3, 1'b0, 1'b0, 1'b0, K_IO | K_MI, K_RO | K_BI, K_EO | K_AI | K_FI | K_SU, "SUB");
        instr(4'h1, 1'b0, 1'b0, 1'b0, K_IO | K_MI, K_RO | K_AI, K_NONE, "LDA");
        instr(4'h4, 1'b0, 1'b0, 1'b0, K_IO | K_MI, K_AO | K_RI, K_NONE, "STA");
        instr(4'h5, 1'b0, 1'b0, 1'b0, K_IO | K_AI, K_NONE, K_NONE, "LDI");
        instr(4'h6, 1'b0, 1'b0, 1'b0, K_IO | K_JMP, K_NONE, K_NONE, "JMP");
        instr(4'h7, 1'b0, 1'b0, 1'b0, K_NONE, K_NONE, K_NONE, "JC_c0");
        instr(4'h7, 1'b1, 1'b1, 1'b0, K_IO | K_JMP, K_NONE, K_NONE, "JC_c1");
        instr(4'h7, 1'b1, 1'b0, 1'b0, K_IO | K_JMP, K_NONE, K_NONE, "JC_c1_drop");
        instr(4'h7, 1'b0, 1'b1, 1'b0, K_NONE, K_NONE, K_NONE, "JC_c0_rise");
        instr(4'h8, 1'b1, 1'b1, 1'b1, K_IO | K_JMP, K_NONE, K_NONE, "JZ_z1");
        instr(4'h8, 1'b1, 1'b1, 1'b0, K_NONE, K_NONE, K_NONE, "JZ_z0");
        instr(4'hE, 1'b0, 1'b0, 1'b0, K_AO | K_OI, K_NONE, K_NONE, "OUT");
        instr(4'h0, 1'b0, 1'b0, 1'b0, K_NONE, K_NONE, K_NONE, "NOP");
        instr(4'h9, 1'b1, 1'b1, 1'b1, K_NONE, K_NONE, K_NONE, "OP9");

        // HLT: freezes at step 3 until reset
        drive(1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, K_F0, "HLT_T0");
        drive(1'b0, 4'hF, 1'b0, 1'b0, 3'd1, 1'b0, K_F1, "HLT_T1");
        drive(1'b0, 4'hF, 1'b0, 1'b0, 3'd2, 1'b0, K_NONE, "HLT_T2");
        for (int i = 0; i < 20; i++)
            drive(1'b0, 4'h2, 1'b1, 1'b1, 3'd3, 1'b1, K_NONE, "halted");
        drive(1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, K_NONE, "HLT_rst");
        drive(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, K_F0, "post_HLT_T0");
        drive(1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b0, K_F1, "post_HLT_T1");

        // Random stream: only the invariants are checked here
        for (int i = 0; i < 10000; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
